// File: rtl/counter_pkg.sv
// Shared constants for the free-running counter and its downstream consumers.
package counter_pkg;
  localparam int unsigned CNT_W_DEF    = 4;
  localparam int unsigned DUTY_RST_DEF = 8;

  // Terminal (all-ones) count for a counter of the given width.
  function automatic int unsigned cnt_tc(input int unsigned w);
    return (1 << w) - 1;
  endfunction

  localparam int unsigned CNT_TC = cnt_tc(CNT_W_DEF);
endpackage

// File: rtl/counter_seq_mon.sv
// Tracks the upstream count: registered copy, wrap detection, sticky sequence error.
module counter_seq_mon
  import counter_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [CNT_W-1:0] q,
  input  logic             err_clr,
  output logic             wrap,
  output logic             seq_err
);
  localparam logic [CNT_W-1:0] TC = CNT_W'(cnt_tc(CNT_W));

  logic [CNT_W-1:0] q_d;
  logic             q_vld;
  logic             q_bad;

  // Holding the value is a legal stall; only +1 (mod 2**CNT_W) advances.
  assign q_bad = q_vld && (q != q_d) && (q != q_d + 1'b1);
  assign wrap  = q_vld && (q_d == TC) && (q == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_d     <= '0;
      q_vld   <= 1'b0;
      seq_err <= 1'b0;
    end else begin
      q_d   <= q;
      q_vld <= 1'b1;
      if (q_bad)        seq_err <= 1'b1;
      else if (err_clr) seq_err <= 1'b0;
    end
  end
endmodule

// File: rtl/counter_pwm.sv
// Registered PWM from the upstream count with a duty setting that only changes at period wrap.
module counter_pwm
  import counter_pkg::*;
#(
  parameter int CNT_W    = CNT_W_DEF,
  parameter int WRAP_W   = 8,
  parameter int DUTY_RST = DUTY_RST_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [CNT_W-1:0]  q,
  input  logic [CNT_W-1:0]  duty_in,
  input  logic              duty_load,
  input  logic              err_clr,
  output logic              pwm_out,
  output logic              period_tick,
  output logic              duty_ack,
  output logic [CNT_W-1:0]  duty_active,
  output logic [WRAP_W-1:0] wrap_cnt,
  output logic              seq_err
);
  localparam logic [CNT_W-1:0] DRST = CNT_W'(DUTY_RST);

  logic             wrap;
  logic             pend;
  logic [CNT_W-1:0] pending;
  logic [CNT_W-1:0] duty_next;

  counter_seq_mon #(.CNT_W(CNT_W)) u_mon (
    .clk     (clk),
    .rst_n   (rst_n),
    .q       (q),
    .err_clr (err_clr),
    .wrap    (wrap),
    .seq_err (seq_err)
  );

  // Switching duty at the q=0 sample keeps every period single-duty.
  assign duty_next = (wrap && pend) ? pending : duty_active;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend        <= 1'b0;
      pending     <= DRST;
      duty_active <= DRST;
      duty_ack    <= 1'b0;
      pwm_out     <= 1'b0;
      period_tick <= 1'b0;
      wrap_cnt    <= '0;
    end else begin
      // A load in the wrap cycle queues behind the value being applied now.
      if (duty_load) begin
        pend    <= 1'b1;
        pending <= duty_in;
      end else if (wrap) begin
        pend <= 1'b0;
      end
      duty_active <= duty_next;
      duty_ack    <= wrap && pend;
      pwm_out     <= (q < duty_next);
      period_tick <= wrap;
      if (wrap) wrap_cnt <= wrap_cnt + 1'b1;
    end
  end
endmodule

// File: doc/counter_pwm.md
Name: counter_pwm

Overview:
- Downstream consumer of the free-running counter's q bus; shares its clk/rst_n.
- Turns the count into a registered PWM waveform with a double-buffered duty setting (new duty applied only at period wrap).
- Counts completed periods, flags count-sequence errors, and emits a per-period tick.
- Sits between the counter and any load or monitor needing a glitch-free duty-cycle output.

Parameters:
- CNT_W, 4, width of the incoming count q; period = 2**CNT_W clocks.
- WRAP_W, 8, width of the period counter wrap_cnt.
- DUTY_RST, 8, duty_active and duty_pend value after reset (CNT_W bits).

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- q  input  CNT_W  count from upstream counter.
- duty_in  input  CNT_W  requested duty (high clocks per period).
- duty_load  input  1  one-cycle strobe; captures duty_in.
- err_clr  input  1  clears seq_err.
- pwm_out  output  1  registered PWM output.
- period_tick  output  1  one-cycle pulse per detected wrap.
- duty_ack  output  1  one-cycle pulse when a pending duty is applied.
- duty_active  output  CNT_W  duty currently in force.
- wrap_cnt  output  WRAP_W  completed periods, modulo 2**WRAP_W.
- seq_err  output  1  sticky count-sequence error.

Behaviour:
- Reset: clk and rst_n as above, asynchronous active-low. While rst_n=0, all outputs and state clear immediately: pwm_out=0, period_tick=0, duty_ack=0, wrap_cnt=0, seq_err=0, duty_active=DUTY_RST, pending value=DUTY_RST, pend flag=0, q_d=0, q_vld=0.
- Tracking: q_d registers q every cycle. q_vld goes to 1 on the first clock after reset release.
- Wrap: wrap = q_vld & (q_d == all-ones) & (q == 0). It is a combinational internal signal.
- Duty handshake: duty_load=1 stores duty_in into the pending register and sets pend. A later load before wrap overwrites pending (last value wins).
- Apply: in a wrap cycle with pend=1, duty_active takes pending at that edge, pend clears, and duty_ack=1 in the next cycle.
- duty_load in a wrap cycle: any previously pending value is applied at this wrap. The new duty_in becomes pending with pend=1 and is applied at the following wrap.
- duty_next = (wrap & pend) ? pending : duty_active.
- PWM: pwm_out <= (q < duty_next), unsigned compare, one clock latency from q.
  - duty 0 gives a constant low output.
  - duty 15 (CNT_W=4) gives 15 high clocks and 1 low clock per period.
  - The new duty affects the sample taken at q=0, so there is no mixed-duty period.
- period_tick <= wrap. wrap_cnt increments on wrap and rolls over from all-ones to 0.
- Sequence check: with q_vld=1, q is legal if q == q_d (stall) or q == q_d+1 mod 2**CNT_W. Any other value sets seq_err at that edge.
  - seq_err stays set until err_clr=1.
  - If an error and err_clr occur in the same cycle, set wins.
  - An illegal q still drives the PWM compare normally and does not count as a wrap unless it meets the wrap condition.
- Reset mid-period: the pending duty is lost. The first post-reset clock does no sequence check and no wrap check.

Decomposition:
- Shared package counter_pkg holds:
  - CNT_W default and the DUTY_RST default constant.
  - An all-ones terminal-count constant, also used by the counter.
- One natural sub-module: counter_seq_mon (q_d, q_vld, wrap detect, seq_err sticky logic). It outputs wrap and seq_err.
- PWM compare and duty double-buffer stay in the top module.

Test Plan:
- Reset, then free-running q 0..15 with no load → duty_active=8; pwm_out high for q=0..7 (one-clock lag), low for 8..15; period_tick once per 16 clocks; wrap_cnt increments 1,2,3.
- duty_load with duty_in=3 while q=5 → pwm_out keeps duty 8 until wrap; at q=0, duty_active=3, duty_ack pulses one cycle later, then high for exactly 3 clocks per period.
- Loads of 2 at q=4 and then 12 at q=9 → only 12 is applied at the next wrap; a single duty_ack.
- duty_load with duty_in=0 in the wrap cycle while pend holds 5 → 5 applied at this wrap; 0 applied at the next wrap; pwm_out then constant 0; two duty_ack pulses 16 clocks apart.
- Inject q jump 6→9 → seq_err=1 and stays set; a stall (q held at 9 for 3 clocks) raises no error; err_clr clears seq_err; err_clr together with a new jump leaves seq_err=1.
- Assert rst_n mid-period with a pending load → outputs return to reset values asynchronously; after release there is no seq_err and no tick on the first clock; wrap_cnt reaches 255 then 0 after 256 periods.
